fetch_queue: RTL

- Instruction fetch queue that sits directly upstream of the frontend select stage.
- Owns the fetch PC (`cpc`), which drives the instruction memory. Holds a small FIFO of already-fetched {pc, instr} pairs and exposes the FIFO head as `bpc`/`bf`.
- Each cycle it consumes the selector's 2-bit `result` code to pop, push and advance the fetch PC.
- Also takes pipeline stall and branch redirect.

---
 rtl/fetch_queue.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue feeding the frontend select stage.
//
// Owns the fetch PC (cpc) that addresses a combinational instruction memory
// and buffers already-fetched {pc, instr} pairs in a small circular FIFO.
// The FIFO head is exposed as bpc/bf. Each cycle the selector's 2-bit result
// code decides whether to pop the head, push the current fetch and advance
// cpc. A taken branch (redirect) flushes the queue and refetches from
// redirect_pc.
//
// Optional feature macro: FETCH_PREFETCH_EN
//   defined   : while stall is high the queue keeps prefetching until full.
//   undefined : stall freezes all state.
//
// Parameters:
//   DEPTH    - FIFO entries, power of two, >= 2
//   RESET_PC - fetch PC after reset
//
// Ports:
//   clk         - clock, all state updates on posedge
//   reset       - asynchronous active-high reset
//   stall       - backend stall, selector decision not accepted
//   result      - selector outcome (INSERT_NOP / POP_DATA / POP_BUF)
//   redirect    - branch/jump resolved taken, flush and refetch
//   redirect_pc - redirect target (low two bits dropped)
//   imem_data   - instruction at cpc, valid in the same cycle
//   cpc         - current fetch PC / imem address
//   bpc, bf     - head entry PC and instruction (cpc / NOP when empty)
//   count       - number of valid entries
//   empty, full - occupancy flags
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [1:0]                 result,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic [31:0]                imem_data,
  output logic [31:0]                cpc,
  output logic [31:0]                bpc,
  output logic [31:0]                bf,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  // Selector result encodings shared with the select stage.
  localparam logic [1:0] INSERT_NOP = 2'b01;
  localparam logic [1:0] POP_DATA   = 2'b10;
  localparam logic [1:0] POP_BUF    = 2'b11;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      fetch_pc;

  logic do_push;
  logic do_pop;
  logic do_adv;

  // Word alignment discards the low target bits.
  logic unused_rpc_bits;
  assign unused_rpc_bits = ^redirect_pc[1:0];

  assign cpc   = fetch_pc;
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

  // An empty queue presents a NOP so the selector never sees a stale branch.
  assign bf  = empty ? 32'h0000_0000 : instr_mem[head];
  assign bpc = empty ? fetch_pc      : pc_mem[head];

  // Decode this cycle's queue actions; redirect and stall take priority over
  // the selector result. A push is suppressed when full unless paired with a
  // pop, and cpc only advances when the fetched word is consumed or stored.
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_adv  = 1'b0;
    if (!redirect) begin
      if (stall) begin
`ifdef FETCH_PREFETCH_EN
        if (!full) begin
          do_push = 1'b1;
          do_adv  = 1'b1;
        end
`endif
      end else begin
        case (result)
          POP_BUF: begin
            do_pop  = !empty;
            do_push = !full || !empty;
            do_adv  = !full || !empty;
          end
          POP_DATA: begin
            do_adv = 1'b1;
          end
          INSERT_NOP: begin
            do_pop = !empty;
          end
          default: ;
        endcase
      end
    end
  end

  // Control state: fetch PC, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
    end else begin
      if (do_adv)  fetch_pc <= fetch_pc + 32'd4;
      if (do_pop)  head     <= head + 1'b1;
      if (do_push) tail     <= tail + 1'b1;
      cnt <= cnt + {{(CNT_W-1){1'b0}}, do_push} - {{(CNT_W-1){1'b0}}, do_pop};
    end
  end

  // Entry storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= imem_data;
    end
  end

endmodule
